y_integ_ctrl: RTL and testbench



---
 rtl/y_integ_pkg.sv | 14 +
 rtl/y_sat_add.sv | 23 ++
 rtl/y_integ_ctrl.sv | 107 ++++++++++
 tb/tb_y_integ_ctrl.sv | 138 +++++++++++++
 4 files changed

// File: rtl/y_integ_pkg.sv
// y_integ_pkg: state encoding, default widths and saturation limits shared by the y integration stages.
package y_integ_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, ACCUM, OUT} state_e;
   localparam int DEF_DATA_W  = 16;
   localparam int DEF_FRAC_W  = 8;
   localparam int DEF_ACC_W   = 24;
   localparam int DEF_TIMEOUT = 15;
   function automatic longint sat_max(input int w);
      return (longint'(1) << (w - 1)) - 1;
   endfunction
   function automatic longint sat_min(input int w);
      return -(longint'(1) << (w - 1));
   endfunction
endpackage

// File: rtl/y_sat_add.sv
// y_sat_add: scales a signed product down by FRAC_W and adds it to an accumulator with saturation.
module y_sat_add import y_integ_pkg::*; #(
   parameter int DATA_W = DEF_DATA_W,
   parameter int FRAC_W = DEF_FRAC_W,
   parameter int ACC_W  = DEF_ACC_W
) (
   input  logic signed [ACC_W-1:0]    acc_i,
   input  logic                       clr_i,
   input  logic signed [2*DATA_W-1:0] prod_i,
   output logic signed [ACC_W-1:0]    sum_o
);
   // One guard bit above the wider operand so the raw sum can never wrap before the clamp.
   localparam int SW = (2 * DATA_W > ACC_W ? 2 * DATA_W : ACC_W) + 1;
   localparam logic signed [SW-1:0] MAX = SW'(sat_max(ACC_W));
   localparam logic signed [SW-1:0] MIN = SW'(sat_min(ACC_W));
   logic signed [SW-1:0] acc_x, prod_x, sum_x;
   always_comb begin
      acc_x  = clr_i ? '0 : SW'(acc_i);
      prod_x = SW'(prod_i) >>> FRAC_W;
      sum_x  = acc_x + prod_x;
      sum_o  = sum_x > MAX ? MAX[ACC_W-1:0] : sum_x < MIN ? MIN[ACC_W-1:0] : sum_x[ACC_W-1:0];
   end
endmodule

// File: rtl/y_integ_ctrl.sv
// y_integ_ctrl: sequences dy/dt samples through an external multi-cycle multiplier
// and accumulates the scaled product into y with saturation and a WAIT timeout.
module y_integ_ctrl import y_integ_pkg::*; #(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int FRAC_W  = DEF_FRAC_W,
   parameter int ACC_W   = DEF_ACC_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     in_dy,
   input  logic [DATA_W-1:0]     in_dt,
   input  logic                  in_clr,
   output logic [DATA_W-1:0]     mul_a,
   output logic [DATA_W-1:0]     mul_b,
   input  logic [2*DATA_W-1:0]   mul_p,
   output logic                  count_en,
   input  logic                  op_done,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ACC_W-1:0]      y_out,
   output logic                  err
);
   localparam int CW = $clog2(TIMEOUT + 1);
   state_e                     state_q, state_d;
   logic [DATA_W-1:0]          mul_a_q, mul_a_d, mul_b_q, mul_b_d;
   logic signed [2*DATA_W-1:0] prod_q, prod_d;
   logic signed [ACC_W-1:0]    acc_q, acc_d, sum;
   logic [CW-1:0]              cnt_q, cnt_d;
   logic                       clr_q, clr_d, out_valid_q, out_valid_d, err_q, err_d;
   y_sat_add #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W)) u_sat_add (
      .acc_i(acc_q), .clr_i(clr_q), .prod_i(prod_q), .sum_o(sum)
   );
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         prod_q      <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         clr_q       <= 1'b0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         prod_q      <= prod_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         clr_q       <= clr_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
      end
   end
   always_comb begin
      state_d     = state_q;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      prod_d      = prod_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      clr_d       = clr_q;
      out_valid_d = out_valid_q;
      err_d       = err_q;
      case (state_q)
         IDLE: if (in_valid) begin
            mul_a_d = in_dy;
            mul_b_d = in_dt;
            clr_d   = in_clr;
            err_d   = err_q & ~in_clr;
            cnt_d   = '0;
            state_d = WAIT;
         end
         // op_done takes priority over a timeout landing in the same cycle.
         WAIT: if (op_done) begin
            prod_d  = mul_p;
            state_d = ACCUM;
         end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = IDLE;
         end else begin
            cnt_d   = cnt_q + CW'(1);
         end
         ACCUM: begin
            acc_d       = sum;
            out_valid_d = 1'b1;
            state_d     = OUT;
         end
         OUT: if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   assign in_ready  = state_q == IDLE;
   assign count_en  = state_q == WAIT;
   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign out_valid = out_valid_q;
   assign y_out     = acc_q;
   assign err       = err_q;
endmodule

// File: tb/tb_y_integ_ctrl.sv
// tb_y_integ_ctrl: directed bench for y_integ_ctrl with a hand-driven op_done counter.
module tb_y_integ_ctrl;
   logic        clock = 1'b0, reset = 1'b0;
   logic        in_valid = 1'b0, in_clr = 1'b0, op_done = 1'b0, out_ready = 1'b1;
   logic [15:0] in_dy = '0, in_dt = '0;
   logic [31:0] mul_p = '0;
   logic        in_ready, count_en, out_valid, err;
   logic [15:0] mul_a, mul_b;
   logic [23:0] y_out;
   int          checks = 0, errors = 0;
   int          n;

   always #5 clock = ~clock;

   y_integ_ctrl dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_dy(in_dy), .in_dt(in_dt), .in_clr(in_clr), .mul_a(mul_a), .mul_b(mul_b),
      .mul_p(mul_p), .count_en(count_en), .op_done(op_done), .out_valid(out_valid),
      .out_ready(out_ready), .y_out(y_out), .err(err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge while idle; op_done is raised so it is sampled on the 4th WAIT edge.
   task automatic txn(input string tag, input logic [15:0] dy, input logic [15:0] dt, input logic clr,
                      input logic [31:0] p, input logic [23:0] exp_y, input logic exp_err, input int hold);
      int c = 0;
      chk({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_dy = dy; in_dt = dt; in_clr = clr;
      @(negedge clock);
      in_valid = 1'b0; in_clr = 1'b0;
      chk({tag, " mul_a"}, 32'(mul_a), 32'(dy));
      chk({tag, " mul_b"}, 32'(mul_b), 32'(dt));
      chk({tag, " err after accept"}, 32'(err), 32'(exp_err));
      for (int k = 0; k < 4; k++) begin
         c += int'(count_en);
         chk({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
         if (k == 3) begin op_done = 1'b1; mul_p = p; end
         @(negedge clock);
      end
      op_done = 1'b0; mul_p = 32'hDEADBEEF; out_ready = (hold == 0);
      chk({tag, " count_en drop"}, 32'(count_en), 32'd0);
      chk({tag, " count_en cycles"}, 32'(c), 32'd4);
      chk({tag, " out_valid accum"}, 32'(out_valid), 32'd0);
      @(negedge clock);
      chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, " y_out"}, 32'(y_out), 32'(exp_y));
      for (int i = 0; i < hold; i++) begin
         @(negedge clock);
         chk({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
         chk({tag, " hold y_out"}, 32'(y_out), 32'(exp_y));
         chk({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clock);
      chk({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
      chk({tag, " in_ready back"}, 32'(in_ready), 32'd1);
      chk({tag, " y_out kept"}, 32'(y_out), 32'(exp_y));
      chk({tag, " err end"}, 32'(err), 32'(exp_err));
   endtask

   task automatic tmo(input string tag, input logic [23:0] exp_y);
      int c = 0, ov = 0;
      in_valid = 1'b1; in_dy = 16'h0011; in_dt = 16'h0022; in_clr = 1'b0;
      @(negedge clock);
      in_valid = 1'b0;
      for (int k = 0; k < 15; k++) begin
         c += int'(count_en);
         ov += int'(out_valid);
         chk({tag, " err during wait"}, 32'(err), 32'd0);
         @(negedge clock);
      end
      chk({tag, " count_en cycles"}, 32'(c), 32'd15);
      chk({tag, " no out_valid"}, 32'(ov + int'(out_valid)), 32'd0);
      chk({tag, " err set"}, 32'(err), 32'd1);
      chk({tag, " idle"}, 32'(in_ready), 32'd1);
      chk({tag, " count_en off"}, 32'(count_en), 32'd0);
      chk({tag, " y_out unchanged"}, 32'(y_out), 32'(exp_y));
   endtask

   initial begin
      repeat (2) @(negedge clock);
      chk("rst in_ready", 32'(in_ready), 32'd1);
      chk("rst count_en", 32'(count_en), 32'd0);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst err", 32'(err), 32'd0);
      chk("rst y_out", 32'(y_out), 32'd0);
      chk("rst mul_a", 32'(mul_a), 32'd0);
      reset = 1'b1;
      @(negedge clock);
      txn("first", 16'h0100, 16'h0080, 1'b1, 32'h00008000, 24'h000080, 1'b0, 0);
      txn("b2b1", 16'h0100, 16'h0100, 1'b1, 32'h00010000, 24'h000100, 1'b0, 0);
      txn("b2b2", 16'h0100, 16'h0100, 1'b0, 32'h00010000, 24'h000200, 1'b0, 0);
      txn("b2b3", 16'h0100, 16'h0100, 1'b0, 32'h00010000, 24'h000300, 1'b0, 0);
      txn("satp load", 16'h7FFF, 16'h0100, 1'b1, 32'h7FFF0000, 24'h7FFF00, 1'b0, 0);
      txn("satp", 16'h00FF, 16'h0100, 1'b0, 32'h00FF0000, 24'h7FFFFF, 1'b0, 0);
      txn("satn load", 16'h8000, 16'h0100, 1'b1, 32'h80001000, 24'h800010, 1'b0, 0);
      txn("satn", 16'hFFF0, 16'h0100, 1'b0, 32'hFFF00000, 24'h800000, 1'b0, 0);
      tmo("tmo1", 24'h800000);
      txn("sticky", 16'h0100, 16'h0100, 1'b0, 32'h00010000, 24'h800100, 1'b1, 0);
      txn("clr err", 16'h0100, 16'h0200, 1'b1, 32'h00020000, 24'h000200, 1'b0, 0);
      txn("hold", 16'h0100, 16'h0100, 1'b0, 32'h00010000, 24'h000300, 1'b0, 10);
      op_done = 1'b1;
      @(negedge clock);
      op_done = 1'b0;
      chk("stray op_done in_ready", 32'(in_ready), 32'd1);
      chk("stray op_done count_en", 32'(count_en), 32'd0);
      chk("stray op_done out_valid", 32'(out_valid), 32'd0);
      chk("stray op_done y_out", 32'(y_out), 32'h300);
      tmo("tmo2", 24'h000300);
      in_valid = 1'b1; in_dy = 16'h1234; in_dt = 16'h0042; in_clr = 1'b0;
      @(negedge clock);
      in_valid = 1'b0;
      @(negedge clock);
      chk("pre-reset count_en", 32'(count_en), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("async count_en", 32'(count_en), 32'd0);
      chk("async out_valid", 32'(out_valid), 32'd0);
      chk("async err", 32'(err), 32'd0);
      chk("async y_out", 32'(y_out), 32'd0);
      chk("async in_ready", 32'(in_ready), 32'd1);
      chk("async mul_a", 32'(mul_a), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      txn("after reset", 16'h0100, 16'h0100, 1'b0, 32'h00010000, 24'h000100, 1'b0, 0);
      n = checks;
      $display("Simulation finished: %0d checks, %0d errors", n, errors);
      $finish;
   end
endmodule
